// File: rtl/xbar_proc_cache_arb.sv
// N-requester crossbar onto the single data-cache port: fixed or round-robin arbitration,
// a registered request stage, per-requester credit counters and tag-routed responses.
module xbar_proc_cache_arb #(
   parameter int NREQ = 4,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128,
   parameter int WORD_W = 64,
   parameter int TAG_W = 12,
   parameter bit RR = 1'b1,
   parameter logic [NREQ-1:0] WIDE_MASK = NREQ'(4'b0010),
   parameter int MAX_OUT = 8,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int SLW = $clog2(LINE_W / WORD_W),
   localparam int CTW = IDW + SLW + TAG_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NREQ*ADDR_W-1:0]     req_addr,
   input  logic [NREQ*4-1:0]          req_op,
   input  logic [NREQ*LINE_W-1:0]     req_data,
   input  logic [NREQ*LINE_W/8-1:0]   req_wmask,
   input  logic [NREQ*TAG_W-1:0]      req_tag,
   input  logic [NREQ-1:0]            req_val,
   output logic [NREQ-1:0]            req_rdy,
   output logic [ADDR_W-1:0]          dcache_req_addr,
   output logic [3:0]                 dcache_req_op,
   output logic [LINE_W-1:0]          dcache_req_data,
   output logic [LINE_W/8-1:0]        dcache_req_wmask,
   output logic [CTW-1:0]             dcache_req_tag,
   output logic                       dcache_req_val,
   input  logic                       dcache_req_rdy,
   input  logic                       dcache_resp_val,
   input  logic [LINE_W-1:0]          dcache_resp_data,
   input  logic [CTW-1:0]             dcache_resp_tag,
   output logic [NREQ-1:0]            resp_val,
   output logic [TAG_W-1:0]           resp_tag,
   output logic [WORD_W-1:0]          resp_data_word,
   output logic [LINE_W-1:0]          resp_data_line,
   output logic                       idle,
   output logic                       err_underflow
);

   localparam int MW = LINE_W / 8;
   localparam int WMW = WORD_W / 8;
   localparam int RATIO = LINE_W / WORD_W;
   localparam int SLO = $clog2(WMW);
   localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

   logic [NREQ-1:0]   elig;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    win_id;
   logic              found;
   logic              load;
   logic              bad_id;
   logic              cnt_zero;

   logic [ADDR_W-1:0] sel_addr;
   logic [3:0]        sel_op;
   logic [LINE_W-1:0] sel_data;
   logic [MW-1:0]     sel_mask;
   logic [TAG_W-1:0]  sel_tag;
   logic [SLW-1:0]    sel_slot;

   logic              val_q, val_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        op_q, op_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic [MW-1:0]     mask_q, mask_d;
   logic [CTW-1:0]    tag_q, tag_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [3:0]        cnt_q [NREQ];
   logic [3:0]        cnt_d [NREQ];
   logic              err_q, err_d;

   logic [IDW-1:0]    resp_id;
   logic [SLW-1:0]    resp_slot;

   assign load = ~val_q | dcache_req_rdy;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = req_val[i] && (cnt_q[i] != MAX_CNT);
      end
   end

   // Round-robin scans upward from the pointer with wrap; fixed mode always scans from 0.
   always_comb begin
      grant = '0;
      win_id = '0;
      found = 1'b0;
      if (RR) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!found && elig[(int'(ptr_q) + k) % NREQ]) begin
               grant[(int'(ptr_q) + k) % NREQ] = 1'b1;
               win_id = IDW'((int'(ptr_q) + k) % NREQ);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[i]) begin
               grant[i] = 1'b1;
               win_id = IDW'(i);
               found = 1'b1;
            end
         end
      end
   end

   assign req_rdy = grant & {NREQ{load & ~reset}};

   // Narrow requesters get their word replicated across the line and the mask steered to its slot.
   always_comb begin
      sel_addr = '0;
      sel_op = '0;
      sel_data = '0;
      sel_mask = '0;
      sel_tag = '0;
      sel_slot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_op = req_op[i*4 +: 4];
            sel_tag = req_tag[i*TAG_W +: TAG_W];
            if (WIDE_MASK[i]) begin
               sel_data = req_data[i*LINE_W +: LINE_W];
               sel_mask = req_wmask[i*MW +: MW];
               sel_slot = '0;
            end else begin
               sel_slot = req_addr[i*ADDR_W + SLO +: SLW];
               sel_data = {RATIO{req_data[i*LINE_W +: WORD_W]}};
               sel_mask = MW'(req_wmask[i*MW +: WMW]) << (int'(sel_slot) * WMW);
            end
         end
      end
   end

   always_comb begin
      val_d = val_q;
      addr_d = addr_q;
      op_d = op_q;
      data_d = data_q;
      mask_d = mask_q;
      tag_d = tag_q;
      ptr_d = ptr_q;
      if (load) begin
         if (found) begin
            val_d = 1'b1;
            addr_d = sel_addr;
            op_d = sel_op;
            data_d = sel_data;
            mask_d = sel_mask;
            tag_d = {win_id, sel_slot, sel_tag};
            ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
         end else begin
            val_d = 1'b0;
         end
      end
   end

   assign resp_id = dcache_resp_tag[CTW-1 -: IDW];
   assign resp_slot = dcache_resp_tag[TAG_W +: SLW];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         resp_val[i] = dcache_resp_val && (resp_id == IDW'(i));
      end
   end

   // A valid response that decodes to no requester is an out-of-range id.
   assign bad_id = dcache_resp_val & ~(|resp_val);
   assign resp_tag = dcache_resp_tag[TAG_W-1:0];
   assign resp_data_word = dcache_resp_data[int'(resp_slot)*WORD_W +: WORD_W];
   assign resp_data_line = dcache_resp_data;

   always_comb begin
      err_d = err_q | bad_id;
      for (int i = 0; i < NREQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (resp_val[i] && (cnt_q[i] == 4'd0)) begin
            err_d = 1'b1;
         end else if (req_rdy[i] && !resp_val[i]) begin
            cnt_d[i] = cnt_q[i] + 4'd1;
         end else if (!req_rdy[i] && resp_val[i]) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
         end
      end
   end

   always_comb begin
      cnt_zero = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (cnt_q[i] != 4'd0) cnt_zero = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val_q <= 1'b0;
         addr_q <= '0;
         op_q <= '0;
         data_q <= '0;
         mask_q <= '0;
         tag_q <= '0;
         ptr_q <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else begin
         val_q <= val_d;
         addr_q <= addr_d;
         op_q <= op_d;
         data_q <= data_d;
         mask_q <= mask_d;
         tag_q <= tag_d;
         ptr_q <= ptr_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign dcache_req_val = val_q;
   assign dcache_req_addr = addr_q;
   assign dcache_req_op = op_q;
   assign dcache_req_data = data_q;
   assign dcache_req_wmask = mask_q;
   assign dcache_req_tag = tag_q;
   assign idle = ~val_q & cnt_zero;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_xbar_proc_cache_arb.sv
// Scoreboard bench for xbar_proc_cache_arb: a fixed-priority and a round-robin (MAX_OUT=2)
// instance share stimulus; a negedge monitor pops expected cache requests and responses.
module tb_xbar_proc_cache_arb;

   localparam int NREQ = 4;
   localparam logic [127:0] RESP_LINE = 128'hCAFEF00D11223344_5566778899AABBCC;

   typedef struct packed {
      logic [31:0]  addr;
      logic [3:0]   op;
      logic [127:0] data;
      logic [15:0]  mask;
      logic [14:0]  tag;
   } reqPkt_t;

   typedef struct packed {
      logic [3:0]   val;
      logic [11:0]  tag;
      logic [63:0]  word;
      logic [127:0] line;
   } respPkt_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [127:0] reqAddr;
   logic [15:0]  reqOp;
   logic [511:0] reqData;
   logic [63:0]  reqWmask;
   logic [47:0]  reqTag;
   logic [3:0]   reqVal;
   logic         dReqRdy;
   logic         dRespVal;
   logic [127:0] dRespData;
   logic [14:0]  dRespTag;

   logic [3:0]   fReqRdy, rReqRdy, fRespVal, rRespVal;
   logic [31:0]  fAddr, rAddr;
   logic [3:0]   fOp, rOp;
   logic [127:0] fData, rData, fLine, rLine;
   logic [15:0]  fMask, rMask;
   logic [14:0]  fTag, rTag;
   logic         fVal, rVal, fIdle, rIdle, fErr, rErr;
   logic [11:0]  fRespTag, rRespTag;
   logic [63:0]  fWord, rWord;

   reqPkt_t  expReqQ[$];
   respPkt_t expRespQ[$];
   reqPkt_t  monReq;
   respPkt_t monResp;
   logic     monVal;
   logic     selFixed = 1'b0;
   int       checks = 0;
   int       errors = 0;

   xbar_proc_cache_arb #(.NREQ(4), .ADDR_W(32), .LINE_W(128), .WORD_W(64), .TAG_W(12),
      .RR(1'b0), .WIDE_MASK(4'b0010), .MAX_OUT(8)) dutFixed (
      .clk(clk), .reset(reset), .req_addr(reqAddr), .req_op(reqOp), .req_data(reqData),
      .req_wmask(reqWmask), .req_tag(reqTag), .req_val(reqVal), .req_rdy(fReqRdy),
      .dcache_req_addr(fAddr), .dcache_req_op(fOp), .dcache_req_data(fData),
      .dcache_req_wmask(fMask), .dcache_req_tag(fTag), .dcache_req_val(fVal),
      .dcache_req_rdy(dReqRdy), .dcache_resp_val(dRespVal), .dcache_resp_data(dRespData),
      .dcache_resp_tag(dRespTag), .resp_val(fRespVal), .resp_tag(fRespTag),
      .resp_data_word(fWord), .resp_data_line(fLine), .idle(fIdle), .err_underflow(fErr));

   xbar_proc_cache_arb #(.NREQ(4), .ADDR_W(32), .LINE_W(128), .WORD_W(64), .TAG_W(12),
      .RR(1'b1), .WIDE_MASK(4'b0010), .MAX_OUT(2)) dutRr (
      .clk(clk), .reset(reset), .req_addr(reqAddr), .req_op(reqOp), .req_data(reqData),
      .req_wmask(reqWmask), .req_tag(reqTag), .req_val(reqVal), .req_rdy(rReqRdy),
      .dcache_req_addr(rAddr), .dcache_req_op(rOp), .dcache_req_data(rData),
      .dcache_req_wmask(rMask), .dcache_req_tag(rTag), .dcache_req_val(rVal),
      .dcache_req_rdy(dReqRdy), .dcache_resp_val(dRespVal), .dcache_resp_data(dRespData),
      .dcache_resp_tag(dRespTag), .resp_val(rRespVal), .resp_tag(rRespTag),
      .resp_data_word(rWord), .resp_data_line(rLine), .idle(rIdle), .err_underflow(rErr));

   always #5 clk = ~clk;

   // The monitor watches whichever instance the current phase is exercising.
   always_comb begin
      monVal = selFixed ? fVal : rVal;
      monReq = selFixed ? {fAddr, fOp, fData, fMask, fTag} : {rAddr, rOp, rData, rMask, rTag};
      monResp = {rRespVal, rRespTag, rWord, rLine};
   end

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] val, input logic rdy, input logic rv,
                                input logic [14:0] rtag);
      @(posedge clk);
      #1;
      reqVal = val;
      dReqRdy = rdy;
      dRespVal = rv;
      dRespTag = rtag;
   endtask

   task automatic setReq(input int i, input logic [31:0] a, input logic [3:0] op,
                         input logic [127:0] d, input logic [15:0] m, input logic [11:0] t);
      reqAddr[i*32 +: 32] = a;
      reqOp[i*4 +: 4] = op;
      reqData[i*128 +: 128] = d;
      reqWmask[i*16 +: 16] = m;
      reqTag[i*12 +: 12] = t;
   endtask

   // Hand-computed cache-side images; index 4 is requester 0 with the slot-1 payload.
   function automatic reqPkt_t expReq(input int i);
      case (i)
         0: return {32'h0000_1000, 4'h1, 128'h00000000000000A0_00000000000000A0, 16'h00FF, 15'h0100};
         1: return {32'h0000_2018, 4'h2, 128'h0123456789ABCDEF_FEDCBA9876543210, 16'hF0F0, 15'h2201};
         2: return {32'h0000_3008, 4'h3, 128'h00000000000000C2_00000000000000C2, 16'h3C00, 15'h5302};
         3: return {32'h0000_4000, 4'h4, 128'h00000000000000D3_00000000000000D3, 16'h0001, 15'h6403};
         default: return {32'h0000_0018, 4'h1, 128'h00000000000000A5_00000000000000A5, 16'h0F00, 15'h1100};
      endcase
   endfunction

   task automatic resetDut();
      @(negedge clk);
      reset = 1'b1;
      reqVal = '0;
      dReqRdy = 1'b0;
      dRespVal = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic checkDrained(input string name);
      applyStimulus(4'b0000, 1'b1, 1'b0, 15'h0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 15'h0);
      @(negedge clk);
      #1;
      checkOutput({name, "ReqQEmpty"}, 256'(expReqQ.size()), 256'd0);
      checkOutput({name, "RespQEmpty"}, 256'(expRespQ.size()), 256'd0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (monVal && dReqRdy) begin
            if (expReqQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL reqUnexpected: got %0h expected none", monReq);
            end else begin
               checkOutput("reqPkt", monReq, expReqQ.pop_front());
            end
         end
         if (!selFixed && (|rRespVal)) begin
            if (expRespQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL respUnexpected: got %0h expected none", monResp);
            end else begin
               checkOutput("respPkt", monResp, expRespQ.pop_front());
            end
         end
      end
   end

   initial begin
      reqVal = 4'hF;
      dReqRdy = 1'b0;
      dRespVal = 1'b0;
      dRespTag = '0;
      dRespData = RESP_LINE;
      setReq(0, 32'h1000, 4'h1, {64'hDEADBEEFDEADBEEF, 64'hA0}, {8'hEE, 8'hFF}, 12'h100);
      setReq(1, 32'h2018, 4'h2, 128'h0123456789ABCDEF_FEDCBA9876543210, 16'hF0F0, 12'h201);
      setReq(2, 32'h3008, 4'h3, {64'h5555555555555555, 64'hC2}, {8'hAA, 8'h3C}, 12'h302);
      setReq(3, 32'h4000, 4'h4, {64'h7777777777777777, 64'hD3}, {8'h77, 8'h01}, 12'h403);

      #12;
      checkOutput("rstReqRdy", 256'(rReqRdy), 256'd0);
      checkOutput("rstVal", 256'(rVal), 256'd0);
      checkOutput("rstTag", 256'(rTag), 256'd0);
      checkOutput("rstIdle", 256'(rIdle), 256'd1);
      checkOutput("rstErr", 256'(rErr), 256'd0);
      checkOutput("rstFixIdle", 256'(fIdle), 256'd1);
      reqVal = '0;
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] fixed priority, requesters 0..2 valid");
      selFixed = 1'b1;
      applyStimulus(4'b0111, 1'b1, 1'b0, 15'h0);
      expReqQ.push_back(expReq(0));
      @(negedge clk);
      checkOutput("fixReqRdy", 256'(fReqRdy), 256'd1);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(4'b0111, 1'b1, 1'b0, 15'h0);
         expReqQ.push_back(expReq(0));
      end
      checkDrained("fix");
      resetDut();
      selFixed = 1'b0;

      $display("[TB] round robin, requesters 0..3 valid");
      for (int n = 0; n < 5; n++) begin
         applyStimulus(4'b1111, 1'b1, 1'b0, 15'h0);
         expReqQ.push_back(expReq(n % 4));
      end
      checkDrained("rr");
      resetDut();

      $display("[TB] backpressure on requester 1");
      applyStimulus(4'b0010, 1'b0, 1'b0, 15'h0);
      expReqQ.push_back(expReq(1));
      for (int n = 0; n < 5; n++) begin
         applyStimulus(4'b0010, 1'b0, 1'b0, 15'h0);
         @(negedge clk);
         checkOutput("bpReqRdy", 256'(rReqRdy), 256'd0);
         checkOutput("bpVal", 256'(rVal), 256'd1);
         checkOutput("bpTag", 256'(rTag), 256'(15'h2201));
         checkOutput("bpData", 256'(rData), 256'(128'h0123456789ABCDEF_FEDCBA9876543210));
      end
      applyStimulus(4'b0010, 1'b1, 1'b0, 15'h0);
      expReqQ.push_back(expReq(1));
      @(negedge clk);
      checkOutput("bpRelease", 256'(rReqRdy), 256'(4'b0010));
      checkDrained("bp");
      resetDut();

      $display("[TB] narrow requester 0 in slot 1");
      setReq(0, 32'h18, 4'h1, {64'hDEADBEEFDEADBEEF, 64'hA5}, {8'hEE, 8'h0F}, 12'h100);
      applyStimulus(4'b0001, 1'b1, 1'b0, 15'h0);
      expReqQ.push_back(expReq(4));
      applyStimulus(4'b0000, 1'b1, 1'b0, 15'h0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 15'h1100);
      expRespQ.push_back({4'b0001, 12'h100, 64'hCAFEF00D11223344, RESP_LINE});
      @(negedge clk);
      checkOutput("slotBusy", 256'(rIdle), 256'd0);
      checkOutput("fixRespVal", 256'(fRespVal), 256'(4'b0001));
      checkOutput("fixRespTag", 256'(fRespTag), 256'(12'h100));
      checkOutput("fixRespWord", 256'(fWord), 256'(64'hCAFEF00D11223344));
      checkOutput("fixRespLine", 256'(fLine), 256'(RESP_LINE));
      applyStimulus(4'b0000, 1'b1, 1'b0, 15'h0);
      @(negedge clk);
      checkOutput("slotIdle", 256'(rIdle), 256'd1);
      checkDrained("slot");
      setReq(0, 32'h1000, 4'h1, {64'hDEADBEEFDEADBEEF, 64'hA0}, {8'hEE, 8'hFF}, 12'h100);
      resetDut();

      $display("[TB] credit limit on requester 2");
      applyStimulus(4'b0100, 1'b1, 1'b0, 15'h0);
      expReqQ.push_back(expReq(2));
      applyStimulus(4'b0100, 1'b1, 1'b0, 15'h0);
      expReqQ.push_back(expReq(2));
      applyStimulus(4'b0100, 1'b1, 1'b0, 15'h0);
      @(negedge clk);
      checkOutput("creditStall1", 256'(rReqRdy), 256'd0);
      applyStimulus(4'b0100, 1'b1, 1'b0, 15'h0);
      @(negedge clk);
      checkOutput("creditStall2", 256'(rReqRdy), 256'd0);
      checkOutput("creditEmptyReg", 256'(rVal), 256'd0);
      applyStimulus(4'b0100, 1'b1, 1'b1, 15'h5302);
      expRespQ.push_back({4'b0100, 12'h302, 64'hCAFEF00D11223344, RESP_LINE});
      @(negedge clk);
      checkOutput("creditStallResp", 256'(rReqRdy), 256'd0);
      applyStimulus(4'b0100, 1'b1, 1'b1, 15'h5302);
      expReqQ.push_back(expReq(2));
      expRespQ.push_back({4'b0100, 12'h302, 64'hCAFEF00D11223344, RESP_LINE});
      @(negedge clk);
      checkOutput("creditIncDec", 256'(rReqRdy), 256'(4'b0100));
      applyStimulus(4'b0100, 1'b1, 1'b0, 15'h0);
      expReqQ.push_back(expReq(2));
      @(negedge clk);
      checkOutput("creditRefill", 256'(rReqRdy), 256'(4'b0100));
      applyStimulus(4'b0100, 1'b1, 1'b0, 15'h0);
      @(negedge clk);
      checkOutput("creditFull", 256'(rReqRdy), 256'd0);
      checkDrained("credit");

      $display("[TB] underflow and mid-request reset");
      checkOutput("errClear", 256'(rErr), 256'd0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 15'h2201);
      expRespQ.push_back({4'b0010, 12'h201, 64'h5566778899AABBCC, RESP_LINE});
      applyStimulus(4'b0000, 1'b1, 1'b0, 15'h0);
      @(negedge clk);
      checkOutput("errSet", 256'(rErr), 256'd1);
      applyStimulus(4'b0000, 1'b1, 1'b0, 15'h0);
      @(negedge clk);
      checkOutput("errSticky", 256'(rErr), 256'd1);
      applyStimulus(4'b0001, 1'b0, 1'b0, 15'h0);
      applyStimulus(4'b0001, 1'b0, 1'b0, 15'h0);
      @(negedge clk);
      checkOutput("midVal", 256'(rVal), 256'd1);
      checkOutput("midIdle", 256'(rIdle), 256'd0);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midRstVal", 256'(rVal), 256'd0);
      checkOutput("midRstIdle", 256'(rIdle), 256'd1);
      checkOutput("midRstErr", 256'(rErr), 256'd0);
      checkOutput("midRstReqRdy", 256'(rReqRdy), 256'd0);
      reqVal = '0;
      @(negedge clk);
      reset = 1'b0;
      checkDrained("end");
      checkOutput("endIdle", 256'(rIdle), 256'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
